// File: rtl/mul_div_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            div_zero;
  logic            overflow;

  modport master (
    output in_valid, op, in1, in2, flush, out_ready,
    input  in_ready, out_valid, out, div_zero, overflow
  );

  modport slave (
    input  in_valid, op, in1, in2, flush, out_ready,
    output in_ready, out_valid, out, div_zero, overflow
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV-style MUL/DIV: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with single-cycle fast path for div special cases.
module mul_div_unit #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input logic           CLK,
  input logic           nRST,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(6);
  localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              neg_q, neg_d, dz_q, dz_d, ov_q, ov_d;

  // Incoming request decode
  logic            is_div, is_rem, s1, s2, neg1, neg2, dz_in, ov_in;
  logic [XLEN-1:0] mag1, mag2;

  assign is_div = bus.op[2];
  assign is_rem = bus.op[2] & bus.op[1];
  assign s1     = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                  (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign s2     = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                  (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign neg1   = s1 & bus.in1[XLEN-1];
  assign neg2   = s2 & bus.in2[XLEN-1];
  assign mag1   = neg1 ? -bus.in1 : bus.in1;
  assign mag2   = neg2 ? -bus.in2 : bus.in2;
  assign dz_in  = is_div && (bus.in2 == '0);
  assign ov_in  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                  (bus.in1 == SMIN) && (bus.in2 == '1);

  // One iteration step. acc holds {hi, lo}: product/multiplier for mul,
  // partial remainder/quotient for div.
  logic [XLEN:0]     sum, top, diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, step;

  always_comb begin
    sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {sum, acc_q[XLEN-1:1]};
    top     = acc_q[2*XLEN-1:XLEN-1];
    diff    = top - {1'b0, b_q};
    div_nxt = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step    = op_q[2] ? div_nxt : mul_nxt;
  end

  function automatic logic [XLEN-1:0] finalize(input logic [2*XLEN-1:0] acc,
                                               input logic [OP_W-1:0]   o,
                                               input logic              neg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = neg ? -acc : acc;
    q    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r    = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (o == OP_MUL)  return prod[XLEN-1:0];
    else if (!o[2])   return prod[2*XLEN-1:XLEN];
    else if (!o[1])   return q;
    else              return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (bus.in_valid && !bus.flush) begin
        op_d  = bus.op;
        dz_d  = dz_in;
        ov_d  = ov_in;
        cnt_d = '0;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_d = is_rem ? neg1 : (neg1 ^ neg2);
        if (dz_in || ov_in) begin
          state_d = DONE;
          if (dz_in) res_d = bus.op[1] ? bus.in1 : '1;
          else       res_d = (bus.op == OP_DIV) ? SMIN : '0;
        end else begin
          state_d = CALC;
          b_d     = is_div ? mag2 : mag1;
          acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = DONE;
            res_d   = finalize(step, op_q, neg_q);
          end
        end
      end
      DONE: if (bus.flush || bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = (state_q == DONE) ? res_q : '0;
  assign bus.div_zero  = (state_q == DONE) & dz_q;
  assign bus.overflow  = (state_q == DONE) & ov_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, corner sequences, random vs model.
module tb_mul_div_unit;
  logic CLK, nRST;
  int   n_chk = 0, n_fail = 0;

  mul_div_unit_if #(.XLEN(32), .OP_W(3)) bus ();
  mul_div_unit #(.XLEN(32), .OP_W(3)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    logic        dz, ov;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference of the instruction set semantics.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, b,
                                output logic [31:0] r, output logic dz, ov);
    logic [63:0] p;
    dz = 1'b0; ov = 1'b0; r = '0; p = '0;
    case (o)
      3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); r = p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); r = p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'b0, b})); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      default: begin
        if (b == 0) begin
          dz = 1'b1;
          r  = (o == 3'd4 || o == 3'd5) ? 32'hFFFF_FFFF : a;
        end else if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ov = 1'b1;
          r  = (o == 3'd4) ? 32'h8000_0000 : 32'h0;
        end else begin
          case (o)
            3'd4:    r = 32'($signed(a) / $signed(b));
            3'd5:    r = a / b;
            3'd6:    r = 32'($signed(a) % $signed(b));
            default: r = a % b;
          endcase
        end
      end
    endcase
  endfunction

  // Issue one request, scramble inputs after accept, count edges to out_valid
  // (accept edge = 1). Consumes the result if out_ready is high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b,
                        output logic [31:0] r, output logic dz, ov, output int lat);
    @(negedge CLK);
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.op = o; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    bus.op = ~o; bus.in1 = $urandom; bus.in2 = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    r = bus.out; dz = bus.div_zero; ov = bus.overflow;
    if (bus.out_valid && bus.out_ready) begin
      @(posedge CLK); #1;
    end
  endtask

  vec_t        vt[$];
  logic [31:0] r, er, held;
  logic        dz, ov, edz, eov;
  int          lat, seen;

  initial begin
    vt.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33});
    vt.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 33});
    vt.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 33});
    vt.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33});
    vt.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 33});
    vt.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 33});
    vt.push_back('{3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 1'b0, 33});
    vt.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1});
    vt.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1});
    vt.push_back('{3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1, 1'b0, 1});
    vt.push_back('{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 33});
    vt.push_back('{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 33});
    vt.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 33});
    vt.push_back('{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 33});

    bus.in_valid = 1'b0; bus.op = '0; bus.in1 = '0; bus.in2 = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    nRST = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out", bus.out, 32'd0);
    chk("rst_flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, r, dz, ov, lat);
      chk($sformatf("vec%0d_out", i), r, vt[i].exp);
      chk($sformatf("vec%0d_flags", i), {30'd0, dz, ov}, {30'd0, vt[i].dz, vt[i].ov});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // Backpressure: result and flags frozen while out_ready is low.
    bus.out_ready = 1'b0;
    run_op(3'd7, 32'h0000_1234, 32'h0, r, dz, ov, lat);
    held = r;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      chk("bp_out_hold", bus.out, held);
      chk("bp_state", {29'd0, bus.out_valid, bus.in_ready, bus.div_zero}, 32'b101);
    end
    bus.out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release", {29'd0, bus.out_valid, bus.in_ready, bus.div_zero}, 32'b010);
    chk("bp_out_zero", bus.out, 32'd0);

    // Flush at CALC cycle 5.
    @(negedge CLK);
    bus.op = 3'd0; bus.in1 = 32'd9; bus.in2 = 32'd9; bus.in_valid = 1'b1;
    @(posedge CLK); #1; bus.in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("calc_out_zero", {bus.out[30:0], bus.out_valid, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    @(posedge CLK); #1; bus.flush = 1'b0;
    chk("flush_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (bus.out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);

    // Flush in IDLE blocks the accept.
    @(negedge CLK);
    bus.op = 3'd0; bus.in1 = 32'd2; bus.in2 = 32'd2; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge CLK); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_blocks", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (bus.out_valid) seen++;
    end
    chk("idle_flush_no_result", 32'(seen), 32'd0);

    // Asynchronous reset at CALC cycle 12.
    @(negedge CLK);
    bus.op = 3'd4; bus.in1 = 32'd100; bus.in2 = 32'd7; bus.in_valid = 1'b1;
    @(posedge CLK); #1; bus.in_valid = 1'b0;
    repeat (11) @(posedge CLK);
    #1; nRST = 1'b0; #1;
    chk("midrst_state", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("midrst_out", bus.out, 32'd0);
    @(negedge CLK); nRST = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, r, dz, ov, lat);
    chk("post_rst_mul", r, 32'd12);
    chk("post_rst_latency", 32'(lat), 32'd33);

    // Random traffic, biased toward the division corner cases.
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      int          sel;
      o = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      model(o, a, b, er, edz, eov);
      run_op(o, a, b, r, dz, ov, lat);
      chk($sformatf("rnd%0d_op%0d_out", n, o), r, er);
      chk($sformatf("rnd%0d_flags", n), {30'd0, dz, ov}, {30'd0, edz, eov});
      chk($sformatf("rnd%0d_latency", n), 32'(lat), (edz || eov) ? 32'd1 : 32'd33);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width in bits (SHALL be even and >= 8).
REQ-002 Parameter: OP_W, 3, width of op select.
REQ-003 Clocking SHALL be one clock CLK, with reset nRST asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 nRST  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 op  input  OP_W  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 in1  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-010 in2  input  XLEN  rs2 operand (divisor / multiplier).
REQ-011 flush  input  1  abort the in-flight operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out  output  XLEN  result.
REQ-015 div_zero  output  1  divide-by-zero occurred (qualified by out_valid).
REQ-016 overflow  output  1  signed-division overflow occurred (qualified by out_valid).

Function
REQ-017 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 Accept SHALL occur when in_valid and in_ready are high on a rising edge; op, in1 and in2 SHALL be captured on that edge.
REQ-021 On a normal accept the FSM SHALL go IDLE->CALC; CALC SHALL last exactly XLEN cycles (counter 0..XLEN-1); then CALC->DONE; out_valid SHALL rise XLEN+1 edges after the accept edge.
REQ-022 Fast path: a division op with in2==0, or DIV/REM with in1==signed-min and in2==all-ones, SHALL go IDLE->DONE on the accept edge, giving 1-cycle latency.
REQ-023 Multiply SHALL be iterative shift-add over magnitudes with a 2*XLEN product.
REQ-024 MUL SHALL return the low XLEN bits of the product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-025 Signedness SHALL be: MULH signed x signed, MULHSU signed in1 x unsigned in2, MULHU unsigned x unsigned.
REQ-026 The sign correction for multiply SHALL be a two's-complement negate of the 2*XLEN product.
REQ-027 Divide SHALL be restoring, 1 quotient bit per CALC cycle, on magnitudes.
REQ-028 The quotient sign SHALL be sign(in1) XOR sign(in2); the remainder sign SHALL be sign(in1) (truncating division).
REQ-029 For divide-by-zero: DIV/DIVU SHALL return all-ones and REM/REMU SHALL return in1; div_zero SHALL be 1.
REQ-030 For signed overflow: DIV SHALL return signed-min and REM SHALL return 0; overflow SHALL be 1.
REQ-031 div_zero and overflow SHALL be 0 for every other op or operand combination.
REQ-032 In DONE, out, div_zero and overflow SHALL hold stable until out_ready is high.
REQ-033 DONE with out_ready SHALL go to IDLE on that edge; no new accept SHALL occur in the same cycle (in_ready is 0 in DONE).
REQ-034 flush in CALC or DONE SHALL force IDLE on the next edge with no result delivered.
REQ-035 flush in IDLE SHALL block accept that cycle.
REQ-036 flush SHALL take priority over out_ready and over completion.
REQ-037 Changes to in1, in2 or op after accept SHALL NOT affect the result.
REQ-038 out SHALL be 0 whenever out_valid is 0.

Reset
REQ-039 nRST low SHALL force IDLE immediately, independent of CLK.
REQ-040 While nRST is low: in_ready=1 (reads 1 during reset), out_valid=0, out=0, div_zero=0, overflow=0, iteration counter=0, operand/accumulator registers=0.
REQ-041 Reset asserted mid-CALC SHALL discard the operation; after release, the first edge with in_valid high SHALL accept normally.

Verification
REQ-042 MUL 0x0000_0007 x 0xFFFF_FFFD -> out=0xFFFF_FFEB, out_valid at edge 33, flags 0.
REQ-043 MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHSU 0xFFFF_FFFF x 0x0000_0002 -> 0xFFFF_FFFF; MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
REQ-044 DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIVU 0xFFFF_FFFF/0x10 -> 0x0FFF_FFFF; all at edge 33.
REQ-045 DIVU 5/0 -> 0xFFFF_FFFF with div_zero=1 at edge 1; REM 0x8000_0000/0xFFFF_FFFF -> 0 with overflow=1 at edge 1.
REQ-046 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out stays constant and in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-047 flush at CALC cycle 5, and nRST pulse at CALC cycle 12 -> no out_valid, in_ready=1 next cycle, and the following MUL 3x4 returns 12.
